// File: rtl/spi_recv.sv
// spi_recv: SPI-slave receiver turning MOSI frames into single-beat AXI writes
module spi_recv #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs,
    output logic [15:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [7:0]  axi_wdata,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic        axi_wlast,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    output logic        rx_overflow,
    output logic        wr_error,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_q, cs_q, sclk_s, cs_s, mosi_s, sclk_rise, cs_rise;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic byte_done;
    logic [1:0] hdr_cnt;
    logic [7:0] addr_hi;
    logic [15:0] addr;
    logic [23:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic full, empty, push, pop, data_byte;
    logic [1:0] state;

    // Edge detection on the synchronised SPI inputs plus FIFO/FSM status decode
    always_comb begin
        sclk_s    = sclk_sync[SYNC_STAGES-1];
        cs_s      = cs_sync[SYNC_STAGES-1];
        mosi_s    = mosi_sync[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_q & ~cs_s;
        cs_rise   = cs_s & ~cs_q;
        empty     = wr_ptr == rd_ptr;
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = (state == S_IDLE) && !empty;
        data_byte = byte_done && (hdr_cnt == 2'd2);
        push      = data_byte && (!full || pop);
        busy      = ~cs_s | ~empty | (state != S_IDLE);
    end

    // Synchronisers; cs idles high so reset never looks like an active frame
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    // Bit shifter; shreg holds the finished byte during the byte_done cycle
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= sclk_rise && (bit_cnt == 3'd7);
            if (cs_rise) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Header decode and address counter; a same-cycle cs edge resets after the byte is used
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            hdr_cnt     <= '0;
            addr_hi     <= '0;
            addr        <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (byte_done) begin
                if (hdr_cnt == 2'd0) begin
                    addr_hi <= shreg;
                    hdr_cnt <= 2'd1;
                end else if (hdr_cnt == 2'd1) begin
                    addr    <= {addr_hi, shreg};
                    hdr_cnt <= 2'd2;
                end else begin
                    addr <= addr + 16'd1;
                    if (!push)
                        rx_overflow <= 1'b1;
                end
            end
            if (cs_rise)
                hdr_cnt <= 2'd0;
        end
    end

    // FIFO pointers; an extra wrap bit distinguishes full from empty
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge axi_aclk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {addr, shreg};
    end

    // AXI write FSM: one outstanding transaction, AW and W channels retire independently
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state       <= S_IDLE;
            axi_awaddr  <= '0;
            axi_wdata   <= '0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_wlast   <= 1'b0;
            axi_bready  <= 1'b0;
            wr_error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        axi_awaddr  <= mem[rd_ptr[AW-1:0]][23:8];
                        axi_wdata   <= mem[rd_ptr[AW-1:0]][7:0];
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        axi_wlast   <= 1'b1;
                        state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (axi_awready)
                        axi_awvalid <= 1'b0;
                    if (axi_wready) begin
                        axi_wvalid <= 1'b0;
                        axi_wlast  <= 1'b0;
                    end
                    if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
                        axi_bready <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (axi_bresp != 2'b00)
                            wr_error <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_recv.md
Name: spi_recv

Overview:
- SPI-slave receiver: the host-to-FPGA counterpart of the SPI send path.
- Deserialises MOSI frames into a 16-bit start address followed by data bytes.
- Each data byte is written to the fabric as a single-beat AXI write at an incrementing address.
- Sits between the external SPI host and the on-chip AXI interconnect, sharing the AXI clock domain.

Parameters:
- FIFO_DEPTH, 8, number of {addr,data} entries buffered between the SPI side and the AXI side (power of 2, ≥2).
- SYNC_STAGES, 2, synchroniser flip-flops on spi_clk, spi_cs and spi_mosi.

Ports:
- axi_aclk  in  1  single system clock.
- axi_areset  in  1  asynchronous, active-high reset.
- spi_clk  in  1  SPI clock from host, mode 0; must be ≤ axi_aclk/8.
- spi_mosi  in  1  serial data, MSB first.
- spi_cs  in  1  chip select, active-low.
- axi_awaddr  out  16  write address.
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address ready.
- axi_wdata  out  8  write data.
- axi_wvalid  out  1  data valid.
- axi_wready  in  1  data ready.
- axi_wlast  out  1  last beat; always 1 while wvalid is high.
- axi_bresp  in  2  write response.
- axi_bvalid  in  1  response valid.
- axi_bready  out  1  response ready.
- rx_overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- wr_error  out  1  sticky: a bresp other than 2'b00 was received.
- busy  out  1  frame active, FIFO non-empty, or AXI transaction outstanding.

Behaviour:
- Reset: asynchronous, active-high. Clears all outputs to 0, empties the FIFO, and puts both FSMs in their idle states.
  - Reset mid-transaction abandons any outstanding AXI handshake without waiting.
  - Sticky flags clear only on reset.
- Input sampling:
  - spi_clk, spi_cs and spi_mosi each pass through SYNC_STAGES flip-flops.
  - A spi_clk rising edge is detected as synchronised 0→1 while synchronised cs is low.
  - On that edge, synchronised mosi is shifted into an 8-bit register (MSB first) and a 3-bit bit counter increments.
- Frame structure (cs low to cs high):
  - byte0 = addr[15:8], byte1 = addr[7:0], byte2.. = data.
  - The address counter loads after byte1 completes.
  - The address counter increments after each data byte is pushed; it wraps 0xFFFF→0x0000.
- Byte completion:
  - On the cycle after the 8th edge, a data byte pushes {addr,data} into the FIFO.
  - If the FIFO is full, the byte is discarded, rx_overflow is set, and the address still increments.
- cs deassert (synchronised rising edge):
  - Partial byte and bit counter are discarded and reset; the header byte counter is reset.
  - A frame with fewer than 3 complete bytes produces no write.
  - A cs edge in the same cycle as a byte completion: the completion is honoured first.
- AXI FSM:
  - IDLE: FIFO non-empty → pop the entry, drive awaddr/wdata, and assert awvalid, wvalid and wlast on the next cycle → SEND.
  - SEND:
    - awvalid drops on the awready handshake; wvalid and wlast drop on the wready handshake, independently. Handshakes may occur in the same cycle or in either order.
    - awaddr and wdata stay stable until their own handshake.
    - When both handshakes are done, assert bready → RESP.
  - RESP: bready stays high until bvalid. On that handshake, set wr_error if bresp≠0 → IDLE.
- At most one outstanding transaction. Back-to-back throughput is 1 byte per (3 + handshake stalls) cycles, well above the SPI byte rate.
- The SPI side operates independently of the AXI FSM; pushes and pops in the same cycle are both allowed at full or empty.
- busy = cs active OR FIFO non-empty OR FSM≠IDLE.

Test Plan:
- Frame 0x12,0x34,0xA5,0x5A with ready/bvalid always high → writes (0x1234,0xA5) then (0x1235,0x5A); wlast=1 on both; bresp=0; no flags set.
- Frame 0xFF,0xFF,0x01,0x02 → writes to 0xFFFF then 0x0000.
- Hold awready low 10 cycles while wready=1 → wvalid drops after its handshake; awvalid and awaddr are held stable; bready asserts only after the AW handshake.
- Stall awready for the duration of a 12-data-byte frame with FIFO_DEPTH=8 → rx_overflow=1; the 8 buffered bytes are written after release, with their original addresses.
- cs high after 5 bits of byte2 → no write issued; the next frame 0x00,0x10,0x77 writes 0x77 to 0x0010.
- bresp=2'b10 on the first write → wr_error=1 and later writes proceed. Then assert axi_areset mid-SEND → awvalid, wvalid, bready and flags go 0 with no clock edge required.
